// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch PC sequencer.
package ifu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] EBREAK_INST      = 32'h0010_0073;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } ifu_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ifu_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Small FIFO of {pc, inst} entries between fetch and decode, with a one-cycle flush.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  ifu_entry_t       push_entry,
    input  logic             pop,
    output ifu_entry_t       head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    ifu_entry_t       mem_reg [DEPTH];

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by count_reg alone.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clock) begin
                if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem_reg[gi] <= push_entry;
                end
            end
        end
    endgenerate

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/ifu_pc_seq.sv
// PC sequencer: issues fetch addresses, buffers returning words toward decode, handles redirects.
// Optional ebreak halt detection is enabled by defining IFU_HALT_DETECT_EN.
module ifu_pc_seq
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] fetch_addr,
    input  logic [31:0] fetch_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        halted
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      pc_reg;
    logic [31:0]      inflight_pc_reg;
    logic             inflight_valid_reg;
    ifu_state_e       state_reg;

    logic             push;
    logic             pop;
    logic             halt_hit;
    logic             issue;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   occ_next;
    ifu_entry_t       push_entry;
    ifu_entry_t       head;

    assign push     = inflight_valid_reg && !redirect_valid;
    assign pop      = out_valid && out_ready;
    assign occ_next = {1'b0, count} + {{CNT_W{1'b0}}, push} - {{CNT_W{1'b0}}, pop};

`ifdef IFU_HALT_DETECT_EN
    assign halt_hit = push && (fetch_data == EBREAK_INST);
`else
    assign halt_hit = 1'b0;
`endif

    // The ebreak push also blocks issue on its own edge so nothing past it is fetched.
    assign issue = (state_reg == RUN) && !redirect_valid && !halt_hit
                   && (occ_next < (CNT_W + 1)'(DEPTH));

    assign push_entry = '{pc: inflight_pc_reg, inst: fetch_data};

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_reg             <= RESET_PC;
            inflight_pc_reg    <= RESET_PC;
            inflight_valid_reg <= 1'b0;
            state_reg          <= RUN;
        end else if (redirect_valid) begin
            pc_reg             <= redirect_pc;
            inflight_valid_reg <= 1'b0;
            state_reg          <= RUN;
        end else begin
            inflight_valid_reg <= issue;
            if (issue) begin
                inflight_pc_reg <= pc_reg;
                pc_reg          <= pc_reg + 32'd4;
            end
            if (halt_hit) state_reg <= HALTED;
        end
    end

    ifu_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_entry(push_entry),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign fetch_addr = pc_reg;
    assign out_valid  = (count != '0);
    assign out_pc     = head.pc;
    assign out_inst   = head.inst;
    assign halted     = (state_reg == HALTED);

endmodule

// File: doc/ifu_pc_seq.md
IFU_PC_SEQ -- requirements
Module: ifu_pc_seq

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, output buffer entries (2..4).
REQ-003 clock  in  1  sole clock; all state updates on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 fetch_addr  out  32  address to fetch stage; data returns on fetch_data one cycle later.
REQ-006 fetch_data  in  32  instruction word for the address presented in the previous cycle.
REQ-007 redirect_valid  in  1  branch/jump/trap redirect request, single-cycle pulse.
REQ-008 redirect_pc  in  32  redirect target; sampled when redirect_valid=1.
REQ-009 out_valid  out  1  out_pc/out_inst valid toward decode.
REQ-010 out_ready  in  1  decode accepts; transfer when out_valid && out_ready.
REQ-011 out_pc  out  32  PC of head instruction.
REQ-012 out_inst  out  32  head instruction word.
REQ-013 halted  out  1  ebreak seen, issue stopped (see Configuration).

Function
REQ-014 fetch_addr SHALL equal the pc register combinationally, at all times.
REQ-015 push = inflight_valid && !redirect_valid; pushes {inflight_pc, fetch_data} into the buffer.
REQ-016 pop = out_valid && out_ready.
REQ-017 issue = state==RUN && !redirect_valid && (count + push - pop) < DEPTH.
REQ-018 On issue: inflight_valid<=1, inflight_pc<=pc, pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC->0); else inflight_valid<=0, pc held.
REQ-019 Issue-to-out_valid latency SHALL be 2 cycles; sustained throughput 1 instr/cycle while out_ready=1.
REQ-020 Buffer is FIFO order; out_valid = count!=0; out_pc/out_inst stable while out_valid && !out_ready.
REQ-021 Simultaneous push and pop at full SHALL be legal; count unchanged.
REQ-022 redirect_valid SHALL take priority over everything: pc<=redirect_pc, inflight_valid<=0, buffer flushed (count<=0), no push/pop counted, state<=RUN; out_valid=0 next cycle.
REQ-023 Fetch results with inflight_valid=0 (stall re-fetch, post-redirect, post-reset) SHALL be discarded.
REQ-024 States: RUN (issuing allowed), HALTED (no issue, buffer still drains); RUN->HALTED per REQ-030; HALTED->RUN on redirect or reset.

Reset
REQ-025 On reset: pc=RESET_PC, inflight_valid=0, count=0, state=RUN.
REQ-026 During and first cycle after reset: out_valid=0, halted=0, fetch_addr=RESET_PC.
REQ-027 Reset SHALL dominate redirect_valid and drop any in-flight or buffered instruction.

Configuration
REQ-028 Macro IFU_HALT_DETECT_EN selects ebreak detection.
REQ-029 Without macro: halted tied 0, state never leaves RUN, 32'h0010_0073 treated as ordinary instruction.
REQ-030 With macro: a push whose word equals 32'h0010_0073 SHALL still be enqueued, set state<=HALTED same edge; halted=1 in HALTED.

Structure
REQ-031 Package ifu_pkg SHALL hold RESET_PC default, EBREAK_INST constant, state enum {RUN, HALTED}, and the {pc,inst} entry typedef.
REQ-032 Sub-module ifu_fifo (DEPTH entries of entry typedef, push/pop/flush/count) SHALL implement the buffer.

Verification
REQ-033 Reset release, out_ready=1, memory = index words -> out_pc 8000_0000, 8000_0004, 8000_0008 on consecutive cycles, first out_valid 2 cycles after first issue.
REQ-034 out_ready=0 for 10 cycles -> count saturates at DEPTH, pc stops at 8000_0008 (DEPTH=2), no instruction lost or duplicated after release.
REQ-035 Redirect to 8000_0100 with 2 entries buffered -> out_valid=0 next cycle, next delivered out_pc=8000_0100; squashed PCs never appear.
REQ-036 pc=FFFF_FFFC -> next fetch_addr=0000_0000.
REQ-037 IFU_HALT_DETECT_EN, ebreak at 8000_0008 -> delivered, halted=1, fetch_addr holds at 8000_000C, redirect to 8000_0000 clears halted.
REQ-038 reset asserted mid-stream with redirect_valid=1 -> pc=RESET_PC, out_valid=0, halted=0 next cycle.
